logic_unit_pipe: RTL and testbench

- Parametrised, pipelined bitwise logic unit; generalises the 32-bit XOR-only array to WIDTH bits and eight selectable operations.
- Adds a running XOR accumulator (checksum mode), a zero flag and a valid/ready handshake on both sides.
- Sits in the ALU datapath beside the adder and shifter; feeds the result mux and flag logic.

---
 rtl/logic_unit_pipe.sv | 175 +++++++++++++++++
 tb/tb_logic_unit_pipe.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit with a running XOR accumulator.
// Stage S1 registers the operand beat. Stage S2 computes the result and
// registers out / out_zero / out_last. Both stages use a valid/ready handshake.
// flush acts as the synchronous clear of the whole unit.
module logic_unit_pipe #(
    parameter int WIDTH  = 32,
    parameter bit ACC_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_zero,
    output logic             out_last
);

    localparam logic [2:0] OP_AND    = 3'b000;
    localparam logic [2:0] OP_OR     = 3'b001;
    localparam logic [2:0] OP_XOR    = 3'b010;
    localparam logic [2:0] OP_NOR    = 3'b011;
    localparam logic [2:0] OP_XNOR   = 3'b100;
    localparam logic [2:0] OP_NAND   = 3'b101;
    localparam logic [2:0] OP_ACC    = 3'b110;
    localparam logic [2:0] OP_ACC_RD = 3'b111;

    // Pure bitwise operations. The accumulator codes fall through to operand A.
    function automatic logic [WIDTH-1:0] bitwise_op(
        input logic [2:0]       sel,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (sel)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            OP_NAND: r = ~(a & b);
            default: r = a;
        endcase
        return r;
    endfunction

    logic             adv1_s;
    logic             adv2_s;
    logic             acc_upd_s;
    logic             s1_valid_r;
    logic [2:0]       s1_op_r;
    logic [WIDTH-1:0] s1_x_r;
    logic [WIDTH-1:0] s1_y_r;
    logic             s1_last_r;
    logic             s2_valid_r;
    logic [WIDTH-1:0] out_r;
    logic             zero_r;
    logic             last_r;
    logic [WIDTH-1:0] acc_s;
    logic [WIDTH-1:0] acc_next_s;
    logic [WIDTH-1:0] result_s;

    assign adv2_s    = ~s2_valid_r | out_ready;
    assign adv1_s    = ~s1_valid_r | adv2_s;
    assign in_ready  = adv1_s & ~flush;
    assign acc_upd_s = adv2_s & s1_valid_r & (s1_op_r == OP_ACC);

    // Result of the beat currently held in S1.
    always_comb begin
        acc_next_s = acc_s ^ s1_x_r ^ s1_y_r;
        result_s   = {WIDTH{1'b0}};
        if (s1_op_r == OP_ACC) begin
            if (ACC_EN) begin
                result_s = acc_next_s;
            end else begin
                result_s = s1_x_r;
            end
        end else if (s1_op_r == OP_ACC_RD) begin
            if (ACC_EN) begin
                result_s = acc_s ^ s1_x_r;
            end else begin
                result_s = s1_x_r;
            end
        end else begin
            result_s = bitwise_op(s1_op_r, s1_x_r, s1_y_r);
        end
    end

    generate
        if (ACC_EN) begin : g_acc
            logic [WIDTH-1:0] acc_r;

            // Accumulator: updated as an ACC beat enters S2, cleared after the last beat of a burst.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_r <= {WIDTH{1'b0}};
                end else if (flush) begin
                    acc_r <= {WIDTH{1'b0}};
                end else if (acc_upd_s) begin
                    if (s1_last_r) begin
                        acc_r <= {WIDTH{1'b0}};
                    end else begin
                        acc_r <= acc_next_s;
                    end
                end else begin
                    acc_r <= acc_r;
                end
            end

            assign acc_s = acc_r;
        end else begin : g_no_acc
            assign acc_s = {WIDTH{1'b0}};
        end
    endgenerate

    // Stage 1: capture the incoming operand beat when the stage can advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_op_r    <= 3'b000;
            s1_x_r     <= {WIDTH{1'b0}};
            s1_y_r     <= {WIDTH{1'b0}};
            s1_last_r  <= 1'b0;
        end else if (flush) begin
            s1_valid_r <= 1'b0;
        end else if (adv1_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_op_r   <= op;
                s1_x_r    <= x;
                s1_y_r    <= y;
                s1_last_r <= in_last;
            end else begin
                s1_last_r <= s1_last_r;
            end
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2: register the result; contents hold while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            out_r      <= {WIDTH{1'b0}};
            zero_r     <= 1'b0;
            last_r     <= 1'b0;
        end else if (flush) begin
            s2_valid_r <= 1'b0;
        end else if (adv2_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_r  <= result_s;
                zero_r <= (result_s == {WIDTH{1'b0}});
                last_r <= s1_last_r;
            end else begin
                out_r <= out_r;
            end
        end else begin
            s2_valid_r <= s2_valid_r;
        end
    end

    assign out_valid = s2_valid_r;
    assign out       = out_r;
    assign out_zero  = zero_r;
    assign out_last  = last_r;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed scenarios plus a randomized
// stream scored against a sequential behavioural model.
module tb_logic_unit_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         out_zero;
    logic         out_last;

    int errors = 0;
    int checks = 0;

    logic         in_fire;
    logic         out_fire;
    logic         obs_valid;
    logic         obs_ready_in;
    logic         obs_zero;
    logic         obs_last;
    logic [W-1:0] obs_out;
    logic [W-1:0] m_acc;

    logic_unit_pipe #(.WIDTH(W), .ACC_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .x(x), .y(y), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_zero(out_zero), .out_last(out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        in_valid = 1'b0;
        op       = 3'b000;
        x        = '0;
        y        = '0;
        in_last  = 1'b0;
        flush    = 1'b0;
    endtask

    // Sample everything just before the next edge, then advance one cycle.
    task automatic tick();
        #1;
        obs_valid    = out_valid;
        obs_ready_in = in_ready;
        obs_out      = out;
        obs_zero     = out_zero;
        obs_last     = out_last;
        in_fire      = in_valid & in_ready;
        out_fire     = out_valid & out_ready;
        @(posedge clk);
        #1;
    endtask

    // Sequential meaning of one beat, applied in acceptance order.
    function automatic logic [W-1:0] model_op(input logic [2:0] o, input logic [W-1:0] a,
                                              input logic [W-1:0] b, input logic lst);
        logic [W-1:0] r;
        case (o)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = a ^ b;
            3'd3: r = ~(a | b);
            3'd4: r = ~(a ^ b);
            3'd5: r = ~(a & b);
            3'd6: begin
                r = m_acc ^ a ^ b;
                m_acc = lst ? '0 : r;
            end
            default: r = m_acc ^ a;
        endcase
        return r;
    endfunction

    task automatic test_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || out !== '0 || out_zero !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b out=%h zero=%b last=%b, expected all 0",
                     out_valid, out, out_zero, out_last);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_held: valid=%b in_ready=%b, expected 0/1", out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_ops();
        logic [W-1:0] ex [6] = '{32'h00F0_1234, 32'hFFF0_FFFF, 32'hFF00_EDCB,
                                 32'h000F_0000, 32'h00FF_1234, 32'hFF0F_EDCB};
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c < 6) begin
                in_valid = 1'b1;
                op       = 3'(c);
                x        = 32'hF0F0_1234;
                y        = 32'h0FF0_FFFF;
            end else begin
                idle_inputs();
            end
            tick();
            if (c == 1) begin
                checks++;
                if (obs_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL ops_latency: out_valid=%b one cycle after accept, expected 0", obs_valid);
                end
            end
            if (c >= 2) begin
                checks++;
                if (obs_valid !== 1'b1 || obs_out !== ex[c-2] || obs_zero !== 1'b0) begin
                    errors++;
                    $display("FAIL ops[%0d]: valid=%b out=%h zero=%b, expected valid=1 out=%h zero=0",
                             c - 2, obs_valid, obs_out, obs_zero, ex[c-2]);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_zero();
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 0) begin
                in_valid = 1'b1;
                op       = 3'b010;
                x        = 32'hDEAD_BEEF;
                y        = 32'hDEAD_BEEF;
            end else begin
                idle_inputs();
            end
            tick();
            if (c == 2) begin
                checks++;
                if (obs_valid !== 1'b1 || obs_out !== '0 || obs_zero !== 1'b1) begin
                    errors++;
                    $display("FAIL zero_flag: valid=%b out=%h zero=%b, expected 1/0/1",
                             obs_valid, obs_out, obs_zero);
                end
            end
        end
    endtask

    task automatic test_acc_burst();
        logic [W-1:0] xs [4] = '{32'h1, 32'h2, 32'h4, 32'h0};
        logic [2:0]   os [4] = '{3'b110, 3'b110, 3'b110, 3'b111};
        logic         ls [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] ex [4] = '{32'h1, 32'h3, 32'h7, 32'h0};
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                in_valid = 1'b1;
                op       = os[c];
                x        = xs[c];
                y        = '0;
                in_last  = ls[c];
            end else begin
                idle_inputs();
            end
            tick();
            if (c >= 2) begin
                checks++;
                if (obs_valid !== 1'b1 || obs_out !== ex[c-2] || obs_last !== ls[c-2]) begin
                    errors++;
                    $display("FAIL acc_burst[%0d]: valid=%b out=%h last=%b, expected 1/%h/%b",
                             c - 2, obs_valid, obs_out, obs_last, ex[c-2], ls[c-2]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] xs [6];
        logic [W-1:0] ys [6];
        int idx   = 0;
        int ndone = 0;
        for (int i = 0; i < 6; i++) begin
            xs[i] = $urandom;
            ys[i] = $urandom;
        end
        for (int c = 0; c < 60 && ndone < 6; c++) begin
            out_ready = (c >= 4);
            if (idx < 6) begin
                in_valid = 1'b1;
                op       = 3'b010;
                x        = xs[idx];
                y        = ys[idx];
            end else begin
                idle_inputs();
            end
            tick();
            if (c == 3) begin
                checks++;
                if (obs_ready_in !== 1'b0 || idx != 2) begin
                    errors++;
                    $display("FAIL bp_in_ready: in_ready=%b accepted=%0d, expected 0 and 2",
                             obs_ready_in, idx);
                end
            end
            if (c == 2 || c == 3) begin
                checks++;
                if (obs_valid !== 1'b1 || obs_out !== (xs[0] ^ ys[0])) begin
                    errors++;
                    $display("FAIL bp_stall_hold: valid=%b out=%h, expected 1/%h",
                             obs_valid, obs_out, xs[0] ^ ys[0]);
                end
            end
            if (in_fire) idx++;
            if (out_fire) begin
                checks++;
                if (obs_out !== (xs[ndone] ^ ys[ndone])) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: out=%h, expected %h", ndone, obs_out, xs[ndone] ^ ys[ndone]);
                end
                ndone++;
            end
        end
        checks++;
        if (ndone != 6 || idx != 6) begin
            errors++;
            $display("FAIL bp_count: delivered=%0d accepted=%0d, expected 6/6", ndone, idx);
        end
        idle_inputs();
        tick();
        checks++;
        if (obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_dup: out_valid=%b after last result, expected 0", obs_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            idle_inputs();
            if (c == 0) begin
                in_valid = 1'b1; op = 3'b110; x = 32'h55;
            end else if (c == 1 || c == 2) begin
                in_valid = 1'b1; op = 3'b010; x = $urandom; y = $urandom;
            end else if (c == 3) begin
                flush = 1'b1; in_valid = 1'b1; op = 3'b010; x = 32'h1234; y = 32'h1;
            end else if (c == 4) begin
                in_valid = 1'b1; op = 3'b111; x = '0;
            end
            tick();
            if (c == 3) begin
                checks++;
                if (obs_ready_in !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_in_ready: got %b during flush, expected 0", obs_ready_in);
                end
            end
            if (c == 4 || c == 5) begin
                checks++;
                if (obs_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_drop[%0d]: out_valid=%b, expected 0", c, obs_valid);
                end
            end
            if (c == 6) begin
                checks++;
                if (obs_valid !== 1'b1 || obs_out !== '0) begin
                    errors++;
                    $display("FAIL flush_acc: valid=%b acc_rd=%h, expected 1/0", obs_valid, obs_out);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            idle_inputs();
            in_valid = 1'b1;
            if (c == 0) begin
                op = 3'b110; x = 32'h30;
            end else begin
                op = 3'b010; x = 32'hA5;
            end
            tick();
        end
        in_valid = 1'b1; op = 3'b010; x = 32'h77;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out !== 32'hA5) begin
            errors++;
            $display("FAIL arst_pre: valid=%b out=%h, expected 1/000000a5", out_valid, out);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out !== '0) begin
            errors++;
            $display("FAIL arst_immediate: valid=%b out=%h, expected 0/0", out_valid, out);
        end
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            idle_inputs();
            if (c == 0) begin
                in_valid = 1'b1; op = 3'b110; x = 32'h9;
            end
            tick();
            if (c == 2) begin
                checks++;
                if (obs_valid !== 1'b1 || obs_out !== 32'h9) begin
                    errors++;
                    $display("FAIL arst_acc: valid=%b out=%h, expected 1/00000009", obs_valid, obs_out);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [W:0]   q [$];
        logic [W:0]   e;
        logic         prev_stall = 1'b0;
        logic [W-1:0] prev_out   = '0;
        logic         prev_zero  = 1'b0;
        logic         prev_last  = 1'b0;
        idle_inputs();
        flush = 1'b1;
        tick();
        m_acc = '0;
        for (int c = 0; c < 420; c++) begin
            idle_inputs();
            if (c < 400) begin
                flush     = ($urandom_range(0, 99) < 3);
                in_valid  = ($urandom_range(0, 3) != 0);
                op        = 3'($urandom_range(0, 7));
                x         = $urandom;
                y         = ($urandom_range(0, 7) == 0) ? x : $urandom;
                in_last   = ($urandom_range(0, 3) == 0);
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
            end
            tick();
            if (prev_stall) begin
                checks++;
                if (obs_valid !== 1'b1 || obs_out !== prev_out || obs_zero !== prev_zero || obs_last !== prev_last) begin
                    errors++;
                    $display("FAIL rnd_hold[%0d]: valid=%b out=%h, expected 1/%h held", c, obs_valid, obs_out, prev_out);
                end
            end
            if (out_fire) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_extra[%0d]: unexpected out=%h, expected no result", c, obs_out);
                end else begin
                    e = q.pop_front();
                    if (obs_out !== e[W-1:0] || obs_last !== e[W] || obs_zero !== (e[W-1:0] == '0)) begin
                        errors++;
                        $display("FAIL rnd_data[%0d]: out=%h last=%b zero=%b, expected %h/%b/%b",
                                 c, obs_out, obs_last, obs_zero, e[W-1:0], e[W], (e[W-1:0] == '0));
                    end
                end
            end
            if (flush) begin
                q.delete();
                m_acc = '0;
            end else if (in_fire) begin
                e = {in_last, model_op(op, x, y, in_last)};
                q.push_back(e);
            end
            prev_stall = obs_valid & ~out_ready & ~flush;
            prev_out   = obs_out;
            prev_zero  = obs_zero;
            prev_last  = obs_last;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rnd_drain: %0d results never delivered, expected 0", q.size());
        end
        idle_inputs();
    endtask

    initial begin
        rst_n     = 1'b1;
        out_ready = 1'b0;
        m_acc     = '0;
        idle_inputs();
        #2;
        rst_n = 1'b0;
        test_reset();
        test_ops();
        test_zero();
        test_acc_burst();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
